// File: rtl/csa_sub_pipe_pkg.sv
// Shared geometry constants and helpers for the pipelined carry-skip subtractor.
// Latency: n/a (package only).
// Backpressure: n/a.
package csa_sub_pipe_pkg;

    // Default operand width and skip-group width.
    localparam int unsigned CSA_WIDTH = 16;
    localparam int unsigned CSA_BLOCK = 4;

    // Number of skip groups that cover one half of the operand.
    function automatic int unsigned csa_ngrp(input int unsigned width, input int unsigned block);
        return (width / 2) / block;
    endfunction

    // The pipeline splits at the half-width point.
    // Each half must therefore hold a whole number of skip groups.
    function automatic bit csa_geom_ok(input int unsigned width, input int unsigned block);
        return (block != 0) && (width != 0) && ((width % (2 * block)) == 0);
    endfunction

endpackage

// File: rtl/csa_sub_pipe_if.sv
// Operand/result handshake bundle for csa_sub_pipe (valid/ready on both sides).
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry flow control in opposite directions.
interface csa_sub_pipe_if
    import csa_sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CSA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/csa_skip_group.sv
// One carry-skip group: BLOCK-bit ripple adder whose carry-out bypasses the ripple when all bits propagate.
// Latency: combinational.
// Backpressure: none (pure datapath).
module csa_skip_group
    import csa_sub_pipe_pkg::*;
#(
    parameter int unsigned BLOCK = CSA_BLOCK
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] prop;
    logic             ripple_c;

    // Ripple the carry through the group bit by bit, producing the sum bits on the way.
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        prop  = x ^ y;
        for (int i = 0; i < int'(BLOCK); i++) begin
            s[i]  = prop[i] ^ carry;
            carry = (x[i] & y[i]) | (prop[i] & carry);
        end
        ripple_c = carry;
    end

    // When every bit propagates, the incoming carry passes straight through.
    // The skip mux selects the carry-in directly in that case.
    always_comb begin
        cout = (&prop) ? cin : ripple_c;
    end

endmodule

// File: rtl/csa_sub_pipe.sv
// Two-stage carry-skip subtractor: diff = a - b - bin, formed as a + ~b + ~bin, split at the half-width carry.
// Latency: 2 cycles from acceptance to out_valid; throughput 1 result per cycle.
// Backpressure: out_ready stalls stage 2, then stage 1; in_ready = !s1_valid || stage 2 advancing.
module csa_sub_pipe
    import csa_sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CSA_WIDTH,
    parameter int unsigned BLOCK = CSA_BLOCK
) (
    input  logic           clk,
    input  logic           rst_n,
    csa_sub_pipe_if.slave  io
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NGRP = csa_ngrp(WIDTH, BLOCK);

    if (!csa_geom_ok(WIDTH, BLOCK)) begin : g_bad_geom
        $error("csa_sub_pipe: WIDTH must be a non-zero multiple of 2*BLOCK");
    end

    // Stage 1 holds the finished low half plus the operands the upper half still needs.
    typedef struct packed {
        logic [HALF-1:0] d_lo;
        logic            mid_c;
        logic [HALF-1:0] a_hi;
        logic [HALF-1:0] nb_hi;
    } s1_dat_t;

    // Stage 2 holds the complete result as presented to the consumer.
    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } s2_dat_t;

    logic    s1_valid_q, s1_valid_d;
    logic    s2_valid_q, s2_valid_d;
    s1_dat_t s1_dat_q,   s1_dat_d;
    s2_dat_t s2_dat_q,   s2_dat_d;

    logic            s1_adv;
    logic            s2_adv;
    logic            accept;

    logic [HALF-1:0] lo_a;
    logic [HALF-1:0] lo_nb;
    logic [HALF-1:0] lo_sum;
    logic            lo_cout;

    logic [HALF-1:0] hi_sum;
    logic            hi_cout;

    // Low half operands. The borrow-in becomes an inverted carry-in.
    assign lo_a  = io.a[HALF-1:0];
    assign lo_nb = ~io.b[HALF-1:0];

    // Low-half skip chain, evaluated on the incoming operands.
    for (genvar g = 0; g < int'(NGRP); g++) begin : g_lo
        logic ci;
        logic co;
        if (g == 0) begin : g_first
            assign ci = ~io.bin;
        end else begin : g_next
            assign ci = g_lo[g-1].co;
        end
        csa_skip_group #(.BLOCK(BLOCK)) u_grp (
            .x    (lo_a[g*BLOCK +: BLOCK]),
            .y    (lo_nb[g*BLOCK +: BLOCK]),
            .cin  (ci),
            .s    (lo_sum[g*BLOCK +: BLOCK]),
            .cout (co)
        );
    end
    assign lo_cout = g_lo[NGRP-1].co;

    // High-half skip chain, evaluated on the stage-1 registers.
    for (genvar g = 0; g < int'(NGRP); g++) begin : g_hi
        logic ci;
        logic co;
        if (g == 0) begin : g_first
            assign ci = s1_dat_q.mid_c;
        end else begin : g_next
            assign ci = g_hi[g-1].co;
        end
        csa_skip_group #(.BLOCK(BLOCK)) u_grp (
            .x    (s1_dat_q.a_hi[g*BLOCK +: BLOCK]),
            .y    (s1_dat_q.nb_hi[g*BLOCK +: BLOCK]),
            .cin  (ci),
            .s    (hi_sum[g*BLOCK +: BLOCK]),
            .cout (co)
        );
    end
    assign hi_cout = g_hi[NGRP-1].co;

    // Handshake and next-state logic.
    // Each stage advances when the stage after it is empty or draining.
    // Outputs hold their last value otherwise.
    always_comb begin
        s2_adv = !s2_valid_q || io.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        accept = io.in_valid && s1_adv;

        s1_valid_d = s1_valid_q;
        s1_dat_d   = s1_dat_q;
        s2_valid_d = s2_valid_q;
        s2_dat_d   = s2_dat_q;

        if (s1_adv) begin
            s1_valid_d = io.in_valid;
        end
        if (accept) begin
            s1_dat_d.d_lo  = lo_sum;
            s1_dat_d.mid_c = lo_cout;
            s1_dat_d.a_hi  = io.a[WIDTH-1:HALF];
            s1_dat_d.nb_hi = ~io.b[WIDTH-1:HALF];
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_dat_d.diff = {hi_sum, s1_dat_q.d_lo};
                s2_dat_d.bout = ~hi_cout;
                // Overflow: the operand signs differ, and the result sign differs from the minuend.
                // The sign bit of ~b is the inverse of the sign bit of b.
                s2_dat_d.ovf  = (s1_dat_q.a_hi[HALF-1] == s1_dat_q.nb_hi[HALF-1]) &&
                                (hi_sum[HALF-1] != s1_dat_q.a_hi[HALF-1]);
            end
        end
    end

    // Pipeline registers. Reset discards anything in flight and clears the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_dat_q   <= '0;
            s2_dat_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_dat_q   <= s1_dat_d;
            s2_dat_q   <= s2_dat_d;
        end
    end

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.diff      = s2_dat_q.diff;
    assign io.bout      = s2_dat_q.bout;
    assign io.ovf       = s2_dat_q.ovf;

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Scoreboard bench for csa_sub_pipe (WIDTH=16, BLOCK=4) using directed vectors with hand-computed results.
// Stimulus pushes expected results when the DUT accepts an operand; a monitor pops and compares on each output transfer.
// Inputs change 1ns after the rising edge; handshakes are observed on the falling edge.
module tb_csa_sub_pipe;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   accept_cnt = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    csa_sub_pipe_if #(.WIDTH(16)) bus ();

    csa_sub_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Back-to-back table: a, b, bin, expected diff, bout, ovf.
    logic [15:0] t_a    [8] = '{16'h1234, 16'h0100, 16'h7FFF, 16'hABCD, 16'h0F0F, 16'h8000, 16'h5555, 16'hFFFF};
    logic [15:0] t_b    [8] = '{16'h0034, 16'h0200, 16'hFFFF, 16'h1111, 16'hF0F0, 16'h8000, 16'hAAAA, 16'h0001};
    logic        t_bin  [8] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
    logic [15:0] t_diff [8] = '{16'h1200, 16'hFF00, 16'h8000, 16'h9ABB, 16'h1E1F, 16'hFFFF, 16'hAAAB, 16'hFFFD};
    logic        t_bout [8] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
    logic        t_ovf  [8] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Present one operand set and hold it until accepted.
    // The expected result is queued when the handshake completes.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin, input exp_t e);
        int  n    = 0;
        bit  done = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(e);
                accept_cnt++;
                done = 1;
            end else if (++n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: a=%h b=%h not accepted after %0d cycles", a, b, n);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: %0d results outstanding after %0d cycles", name, sb_q.size(), n);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: diff=%h bout=%b ovf=%b with nothing outstanding",
                         bus.diff, bus.bout, bus.ovf);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.diff, bus.bout, bus.ovf} !== {mon_e.diff, mon_e.bout, mon_e.ovf}) begin
                    bad++;
                    $display("FAIL result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                             bus.diff, bus.bout, bus.ovf, mon_e.diff, mon_e.bout, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset asserted mid-cycle takes effect immediately.
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_diff", {16'd0, bus.diff}, 32'h0000);
        check("rst_bout", {31'd0, bus.bout}, 32'd0);
        #19 rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic subtraction and first-result latency.
        send(16'h0008, 16'h0003, 1'b0, '{16'h0005, 1'b0, 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        check("latency", n, 32'd2);
        wait_drain("basic1");

        send(16'h0001, 16'h000A, 1'b1, '{16'hFFF6, 1'b1, 1'b0});
        send(16'hFFFF, 16'hFFFF, 1'b0, '{16'h0000, 1'b0, 1'b0});
        send(16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1});
        send(16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0});
        wait_drain("boundary");

        // Back-to-back: one accept per cycle.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(t_a[i], t_b[i], t_bin[i], '{t_diff[i], t_bout[i], t_ovf[i]});
        end
        check("b2b_cycles", cyc - c0, 32'd8);
        wait_drain("b2b");

        // Backpressure: the consumer stalls while the producer streams.
        bus.out_ready = 1'b0;
        accept_cnt    = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send(16'(i * 16'h0010), 16'(i), 1'b0, '{16'(i * 16'h000F), 1'b0, 1'b0});
                end
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                check("bp_accepts", accept_cnt, 32'd2);
                check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
                check("bp_diff_stall1", {16'd0, bus.diff}, 32'h000F);
                @(negedge clk);
                check("bp_diff_stall2", {16'd0, bus.diff}, 32'h000F);
                check("bp_in_ready_still_low", {31'd0, bus.in_ready}, 32'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Reset with two items in flight discards them.
        bus.out_ready = 1'b0;
        send(16'h0100, 16'h0001, 1'b0, '{16'h00FF, 1'b0, 1'b0});
        send(16'h0200, 16'h0001, 1'b0, '{16'h01FF, 1'b0, 1'b0});
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0});
        wait_drain("after_reset");

        // Result holds its last value once out_valid drops.
        repeat (3) @(negedge clk);
        check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_diff_hold", {16'd0, bus.diff}, 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
